// File: rtl/conv_pkg.sv
// Shared types for the conv kernel scheduler: sequencer states and tap counts per mode.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        RUN,
        DRAIN,
        DONE
    } sched_state_e;

    localparam int TAPS_1X1 = 1;
    localparam int TAPS_3X3 = 9;

    function automatic logic [3:0] taps_of(input logic conv3x3);
        return conv3x3 ? 4'(TAPS_3X3) : 4'(TAPS_1X1);
    endfunction

endpackage

// File: rtl/conv_sched_addr_gen.sv
// Tap / pixel / output-channel counters and the data and weight buffer addresses derived from them.
module conv_sched_addr_gen
    import conv_pkg::*;
#(
    parameter int NOC_W   = 10,
    parameter int NPIX_W  = 16,
    parameter int DADDR_W = 20,
    parameter int WADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               conv3x3,
    input  logic [NOC_W-1:0]   noc,
    input  logic [NPIX_W-1:0]  npix,
    input  logic               adv,
    input  logic               oc_inc,
    output logic               at_last_pos,
    output logic               last_oc,
    output logic [NOC_W-1:0]   oc,
    output logic [DADDR_W-1:0] daddr,
    output logic [WADDR_W-1:0] waddr
);

    localparam int DP_W = NPIX_W + 4;
    localparam int WP_W = NOC_W + 4;

    logic [3:0]        taps;
    logic [3:0]        tap_q, tap_d;
    logic [NPIX_W-1:0] pix_q, pix_d;
    logic [NOC_W-1:0]  oc_q, oc_d;
    logic              tap_last;
    logic              pix_last;
    logic [DP_W-1:0]   dprod;
    logic [WP_W-1:0]   wprod;

    assign taps        = taps_of(conv3x3);
    assign tap_last    = (tap_q == taps - 4'd1);
    assign pix_last    = (pix_q == npix - NPIX_W'(1));
    assign at_last_pos = tap_last && pix_last;
    assign last_oc     = (oc_q == noc - NOC_W'(1));

    // The pixel counter wraps to zero on the final issue so the next channel starts clean.
    always_comb begin
        tap_d = tap_q;
        pix_d = pix_q;
        oc_d  = oc_q;
        if (clear) begin
            tap_d = '0;
            pix_d = '0;
            oc_d  = '0;
        end else begin
            if (adv) begin
                if (tap_last) begin
                    tap_d = '0;
                    pix_d = pix_last ? '0 : pix_q + NPIX_W'(1);
                end else begin
                    tap_d = tap_q + 4'd1;
                end
            end
            if (oc_inc) begin
                oc_d = oc_q + NOC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_q <= '0;
            pix_q <= '0;
            oc_q  <= '0;
        end else begin
            tap_q <= tap_d;
            pix_q <= pix_d;
            oc_q  <= oc_d;
        end
    end

    assign dprod = DP_W'(pix_q) * DP_W'(taps) + DP_W'(tap_q);
    assign wprod = WP_W'(oc_q) * WP_W'(taps) + WP_W'(tap_q);
    assign daddr = DADDR_W'(dprod);
    assign waddr = WADDR_W'(wprod);
    assign oc    = oc_q;

endmodule

// File: rtl/conv_kern_sched.sv
// Layer sequencer for the conv kernel: per-channel parameter fetch, buffer read issue and pipeline drain.
// Define CONV_SCHED_PERF_EN to add the perf_cycles / perf_stalls counters.
module conv_kern_sched
    import conv_pkg::*;
#(
    parameter int PARAM_BITS = 16,
    parameter int NOC_W      = 10,
    parameter int NPIX_W     = 16,
    parameter int DADDR_W    = 20,
    parameter int WADDR_W    = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cfg_conv3x3,
    input  logic [NOC_W-1:0]      cfg_noc,
    input  logic [NPIX_W-1:0]     cfg_npix,
    input  logic                  data_rdy,
    output logic                  prm_rd,
    output logic [NOC_W-1:0]      prm_addr,
    input  logic [PARAM_BITS-1:0] prm_scale,
    input  logic [PARAM_BITS-1:0] prm_bias,
    output logic [PARAM_BITS-1:0] scale,
    output logic [PARAM_BITS-1:0] bias,
    output logic                  is_conv3x3,
    output logic                  buf_rd,
    output logic [DADDR_W-1:0]    daddr,
    output logic [WADDR_W-1:0]    waddr,
    output logic                  vld_i,
    input  logic                  kern_vld_o,
    output logic                  busy,
    output logic                  done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls
`endif
);

    sched_state_e          state_q, state_d;
    logic                  conv3x3_q, conv3x3_d;
    logic [NOC_W-1:0]      noc_q, noc_d;
    logic [NPIX_W-1:0]     npix_q, npix_d;
    logic [PARAM_BITS-1:0] scale_q, scale_d;
    logic [PARAM_BITS-1:0] bias_q, bias_d;
    logic [NPIX_W-1:0]     vcnt_q, vcnt_d;
    logic [NPIX_W-1:0]     vcnt_inc;
    logic                  vld_q, vld_d;
    logic                  gen_clear;
    logic                  oc_inc;
    logic                  at_last_pos;
    logic                  last_oc;
    logic                  last_issue;
    logic                  count_en;
    logic [NOC_W-1:0]      oc;

    assign buf_rd     = (state_q == RUN) && data_rdy;
    assign last_issue = buf_rd && at_last_pos;
    assign count_en   = kern_vld_o && ((state_q == RUN) || (state_q == DRAIN));
    assign vcnt_inc   = vcnt_q + NPIX_W'(count_en);

    // Kernel outputs can already appear while later pixels are still being issued, so the
    // per-channel output count runs through RUN and DRAIN; scale/bias only move in LATCH.
    always_comb begin
        state_d   = state_q;
        conv3x3_d = conv3x3_q;
        noc_d     = noc_q;
        npix_d    = npix_q;
        scale_d   = scale_q;
        bias_d    = bias_q;
        vcnt_d    = vcnt_q;
        vld_d     = buf_rd;
        gen_clear = 1'b0;
        oc_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    conv3x3_d = cfg_conv3x3;
                    noc_d     = cfg_noc;
                    npix_d    = cfg_npix;
                    vcnt_d    = '0;
                    gen_clear = 1'b1;
                    state_d   = ((cfg_noc == '0) || (cfg_npix == '0)) ? DONE : LOAD;
                end
            end
            LOAD: begin
                state_d = LATCH;
            end
            LATCH: begin
                scale_d = prm_scale;
                bias_d  = prm_bias;
                state_d = RUN;
            end
            RUN: begin
                vcnt_d = vcnt_inc;
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                vcnt_d = vcnt_inc;
                if (vcnt_inc == npix_q) begin
                    vcnt_d = '0;
                    if (last_oc) begin
                        state_d = DONE;
                    end else begin
                        oc_inc  = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            conv3x3_q <= 1'b0;
            noc_q     <= '0;
            npix_q    <= '0;
            scale_q   <= '0;
            bias_q    <= '0;
            vcnt_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            conv3x3_q <= conv3x3_d;
            noc_q     <= noc_d;
            npix_q    <= npix_d;
            scale_q   <= scale_d;
            bias_q    <= bias_d;
            vcnt_q    <= vcnt_d;
            vld_q     <= vld_d;
        end
    end

    conv_sched_addr_gen #(
        .NOC_W   (NOC_W),
        .NPIX_W  (NPIX_W),
        .DADDR_W (DADDR_W),
        .WADDR_W (WADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (gen_clear),
        .conv3x3     (conv3x3_q),
        .noc         (noc_q),
        .npix        (npix_q),
        .adv         (buf_rd),
        .oc_inc      (oc_inc),
        .at_last_pos (at_last_pos),
        .last_oc     (last_oc),
        .oc          (oc),
        .daddr       (daddr),
        .waddr       (waddr)
    );

    assign prm_rd     = (state_q == LOAD);
    assign prm_addr   = oc;
    assign scale      = scale_q;
    assign bias       = bias_q;
    assign is_conv3x3 = conv3x3_q;
    assign vld_i      = vld_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    // Both counters restart on an accepted start and freeze once the sequencer is back in IDLE.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if ((state_q == IDLE) && start) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if ((state_q != IDLE) && (perf_cycles_q != '1)) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if ((state_q == RUN) && !data_rdy && (perf_stalls_q != '1)) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
